// File: rtl/syscall_console.sv
// syscall_console -- service end of the processor's syscall interface.
//
// When the core raises `syscall`, the $v0/$a0 values are latched and the
// console service runs while `busy` stalls the PC:
//   print-int  : signed decimal of a0 (32-cycle double-dabble), optional newline
//   print-char : a0[7:0]
//   exit       : sticky `halted`, busy held high forever (until reset)
//   other      : one-cycle `error` pulse, then completion
// Bytes leave over a valid/ready port; a byte moves when char_valid &&
// char_ready are both high at a rising clock edge.
//
// Ports:
//   clock       system clock, all state changes on posedge
//   reset       synchronous active-high reset
//   syscall     level request, sampled only in IDLE
//   v0, a0      service code and argument (latched on acceptance)
//   busy        high while a request is in service
//   done        one-cycle completion pulse
//   char_valid  byte on char_data is offered
//   char_data   ASCII byte
//   char_ready  sink accepts the offered byte
//   halted      sticky after an exit service
//   error       one-cycle pulse on an unknown service code
module syscall_console #(
  parameter bit          NEWLINE_EN      = 1'b1,
  parameter logic [7:0]  NEWLINE_CHAR    = 8'h0A,
  parameter logic [31:0] CODE_PRINT_INT  = 32'd1,
  parameter logic [31:0] CODE_EXIT       = 32'd10,
  parameter logic [31:0] CODE_PRINT_CHAR = 32'd11
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        syscall,
  input  logic [31:0] v0,
  input  logic [31:0] a0,
  output logic        busy,
  output logic        done,
  output logic        char_valid,
  output logic [7:0]  char_data,
  input  logic        char_ready,
  output logic        halted,
  output logic        error
);

  // ERR is the single cycle that carries the error pulse before DONE.
  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    CONVERT = 4'd1,
    SIGN    = 4'd2,
    DIGITS  = 4'd3,
    NL      = 4'd4,
    CHAR    = 4'd5,
    ERR     = 4'd6,
    DONE    = 4'd7,
    HALT    = 4'd8
  } state_t;

  // One double-dabble iteration: add 3 to every BCD digit >= 5, then shift
  // the combined {bcd, bin} register left by one.
  function automatic logic [71:0] dabble_step(input logic [39:0] bcd,
                                               input logic [31:0] bin);
    logic [39:0] adj;
    adj = bcd;
    for (int i = 0; i < 10; i++) begin
      if (adj[i*4 +: 4] >= 4'd5) begin
        adj[i*4 +: 4] = adj[i*4 +: 4] + 4'd3;
      end
    end
    return {adj[38:0], bin, 1'b0};
  endfunction

  // Digit at position idx (0 = least significant).
  function automatic logic [3:0] digit_at(input logic [39:0] bcd,
                                          input logic [3:0]  idx);
    logic [3:0] d;
    d = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (idx == 4'(i)) begin
        d = bcd[i*4 +: 4];
      end
    end
    return d;
  endfunction

  // Position of the most significant non-zero digit; 0 for a zero value so
  // that a lone '0' is printed.
  function automatic logic [3:0] lead_digit(input logic [39:0] bcd);
    logic [3:0] l;
    l = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (bcd[i*4 +: 4] != 4'd0) begin
        l = 4'(i);
      end
    end
    return l;
  endfunction

  function automatic logic [7:0] to_ascii(input logic [3:0] d);
    return {4'h3, d};
  endfunction

  state_t      state_r;
  logic [39:0] bcd_r;
  logic [31:0] bin_r;
  logic        neg_r;
  logic [4:0]  cnt_r;
  logic [3:0]  idx_r;
  logic        busy_r;
  logic        done_r;
  logic        char_valid_r;
  logic [7:0]  char_data_r;
  logic        halted_r;
  logic        error_r;

  logic [71:0] step_s;
  logic [39:0] bcd_fin_s;
  logic [3:0]  lead_s;

  // The final conversion step feeds the first byte directly, so the first
  // digit is offered on the edge that completes the 32nd iteration.
  assign step_s    = dabble_step(bcd_r, bin_r);
  assign bcd_fin_s = step_s[71:32];
  assign lead_s    = lead_digit(bcd_fin_s);

  assign busy       = busy_r;
  assign done       = done_r;
  assign char_valid = char_valid_r;
  assign char_data  = char_data_r;
  assign halted     = halted_r;
  assign error      = error_r;

  // Service FSM with all outputs registered.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= IDLE;
      bcd_r        <= 40'd0;
      bin_r        <= 32'd0;
      neg_r        <= 1'b0;
      cnt_r        <= 5'd0;
      idx_r        <= 4'd0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      char_valid_r <= 1'b0;
      char_data_r  <= 8'h00;
      halted_r     <= 1'b0;
      error_r      <= 1'b0;
    end else begin
      done_r  <= 1'b0;
      error_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (syscall) begin
            busy_r <= 1'b1;
            bin_r  <= a0[31] ? (~a0 + 32'd1) : a0;
            neg_r  <= a0[31];
            bcd_r  <= 40'd0;
            cnt_r  <= 5'd0;
            if (v0 == CODE_PRINT_INT) begin
              state_r <= CONVERT;
            end else if (v0 == CODE_PRINT_CHAR) begin
              state_r      <= CHAR;
              char_valid_r <= 1'b1;
              char_data_r  <= a0[7:0];
            end else if (v0 == CODE_EXIT) begin
              state_r  <= HALT;
              halted_r <= 1'b1;
            end else begin
              state_r <= ERR;
              error_r <= 1'b1;
            end
          end
        end
        CONVERT: begin
          bcd_r <= bcd_fin_s;
          bin_r <= step_s[31:0];
          cnt_r <= cnt_r + 5'd1;
          if (cnt_r == 5'd31) begin
            char_valid_r <= 1'b1;
            idx_r        <= lead_s;
            if (neg_r) begin
              state_r     <= SIGN;
              char_data_r <= 8'h2D;
            end else begin
              state_r     <= DIGITS;
              char_data_r <= to_ascii(digit_at(bcd_fin_s, lead_s));
            end
          end
        end
        SIGN: begin
          if (char_ready) begin
            state_r     <= DIGITS;
            char_data_r <= to_ascii(digit_at(bcd_r, idx_r));
          end
        end
        DIGITS: begin
          if (char_ready) begin
            if (idx_r != 4'd0) begin
              idx_r       <= idx_r - 4'd1;
              char_data_r <= to_ascii(digit_at(bcd_r, idx_r - 4'd1));
            end else if (NEWLINE_EN) begin
              state_r     <= NL;
              char_data_r <= NEWLINE_CHAR;
            end else begin
              state_r      <= DONE;
              char_valid_r <= 1'b0;
              char_data_r  <= 8'h00;
              done_r       <= 1'b1;
              busy_r       <= 1'b0;
            end
          end
        end
        NL, CHAR: begin
          if (char_ready) begin
            state_r      <= DONE;
            char_valid_r <= 1'b0;
            char_data_r  <= 8'h00;
            done_r       <= 1'b1;
            busy_r       <= 1'b0;
          end
        end
        ERR: begin
          state_r <= DONE;
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
        end
        DONE: begin
          state_r <= IDLE;
        end
        HALT: begin
          state_r <= HALT;
        end
        default: begin
          state_r      <= IDLE;
          busy_r       <= 1'b0;
          char_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule
